wb_arbiter2: RTL and testbench



---
 rtl/wb_arbiter2_if.sv | 35 +++
 rtl/wb_arbiter2.sv | 173 +++++++++++++++++
 tb/tb_wb_arbiter2.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// rtl/wb_arbiter2_if.sv - Wishbone pipelined bus bundle used by the two-master arbiter
//
// One instance carries a single Wishbone pipelined link.
// The master modport drives the request side; the slave modport drives the response side.
//   cyc    master -> slave  bus cycle in progress
//   stb    master -> slave  request strobe
//   we     master -> slave  write enable
//   adr    master -> slave  address, AW bits
//   dat_w  master -> slave  write data, DW bits
//   dat_r  slave -> master  read data, DW bits
//   ack    slave -> master  request completed
//   stall  slave -> master  request not accepted this cycle
interface wb_arbiter2_if #(
    parameter int AW = 16,
    parameter int DW = 16
) ();
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          ack;
    logic          stall;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  dat_r, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output dat_r, ack, stall
    );
endinterface

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master, one-slave Wishbone pipelined bus arbiter
//
// Grants a whole bus cycle (cyc) to one master and routes stb/we/adr/dat and
// stall/ack between that master and the single slave. Tracks accepted but not
// yet acknowledged requests and stalls the granted master at MAX_OUT.
//
// Ports:
//   clk     in   bus clock, all state on rising edge
//   rst_n   in   asynchronous active-low reset
//   m0_bus  slave modport   master 0 link (cyc/stb/we/adr/dat_w in; dat_r/ack/stall out)
//   m1_bus  slave modport   master 1 link, same as m0_bus
//   s_bus   master modport  link to the shared slave
//
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN
//   defined   : ties in IDLE go to the master not granted last time
//   undefined : fixed priority, master 0 wins ties
module wb_arbiter2 #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MAX_OUT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_arbiter2_if.slave   m0_bus,
    wb_arbiter2_if.slave   m1_bus,
    wb_arbiter2_if.master  s_bus
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_upd;
    logic          full;
    logic          accept;
    logic          ack_valid;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // 1 = master 1 was granted last, so master 0 wins the first tie after reset.
    logic          last_q, last_d;
`endif

    assign full = (count_q == MAX_CNT);

    // A request is accepted when it is presented and the slave does not stall it.
    assign accept = s_bus.stb & ~s_bus.stall;

    // An ack with nothing outstanding is a slave protocol error and is not counted.
    assign ack_valid = s_bus.ack & (count_q != '0);

    always_comb begin
        count_upd = count_q;
        case ({accept, ack_valid})
            2'b10:   count_upd = count_q + CW'(1);
            2'b01:   count_upd = count_q - CW'(1);
            default: count_upd = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next-state: arbitration only in IDLE, so grants are separated by an idle cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                count_d = '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
                if (m0_bus.cyc && (!m1_bus.cyc || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_bus.cyc) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
`else
                if (m0_bus.cyc) begin
                    state_d = GNT0;
                end else if (m1_bus.cyc) begin
                    state_d = GNT1;
                end
`endif
            end
            GNT0: begin
                // Dropping cyc ends (or aborts) the cycle; outstanding work is forgotten.
                if (!m0_bus.cyc) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_upd;
                end
            end
            GNT1: begin
                if (!m1_bus.cyc) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_upd;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Bus routing. Everything is combinational from state so an async reset
    // deasserts all slave and master handshakes immediately.
    always_comb begin
        s_bus.cyc    = 1'b0;
        s_bus.stb    = 1'b0;
        s_bus.we     = 1'b0;
        s_bus.adr    = '0;
        s_bus.dat_w  = '0;
        m0_bus.ack   = 1'b0;
        m1_bus.ack   = 1'b0;
        // A master that is not granted is held off whenever it strobes.
        m0_bus.stall = m0_bus.cyc & m0_bus.stb;
        m1_bus.stall = m1_bus.cyc & m1_bus.stb;
        case (state_q)
            GNT0: begin
                s_bus.cyc    = m0_bus.cyc;
                s_bus.stb    = m0_bus.cyc & m0_bus.stb & ~full;
                s_bus.we     = m0_bus.we;
                s_bus.adr    = m0_bus.adr;
                s_bus.dat_w  = m0_bus.dat_w;
                m0_bus.ack   = s_bus.ack;
                m0_bus.stall = s_bus.stall | full;
            end
            GNT1: begin
                s_bus.cyc    = m1_bus.cyc;
                s_bus.stb    = m1_bus.cyc & m1_bus.stb & ~full;
                s_bus.we     = m1_bus.we;
                s_bus.adr    = m1_bus.adr;
                s_bus.dat_w  = m1_bus.dat_w;
                m1_bus.ack   = s_bus.ack;
                m1_bus.stall = s_bus.stall | full;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; each master qualifies it with its own ack.
    assign m0_bus.dat_r = s_bus.dat_r;
    assign m1_bus.dat_r = s_bus.dat_r;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - scoreboard testbench for wb_arbiter2
module tb_wb_arbiter2;
`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam int RR = 1;
`else
    localparam int RR = 0;
`endif

    logic clk;
    logic rst_n;

    wb_arbiter2_if #(.AW(16), .DW(16)) m0_if ();
    wb_arbiter2_if #(.AW(16), .DW(16)) m1_if ();
    wb_arbiter2_if #(.AW(16), .DW(16)) s_if ();

    wb_arbiter2 #(.AW(16), .DW(16), .MAX_OUT(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m0_bus (m0_if),
        .m1_bus (m1_if),
        .s_bus  (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ack0_n   = 0;
    int ack1_n   = 0;

    logic [15:0] exp0[$];
    logic [15:0] exp1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic drive(input int k, input logic c, input logic s, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (k == 0) begin
            m0_if.cyc = c; m0_if.stb = s; m0_if.we = w; m0_if.adr = a; m0_if.dat_w = d;
        end else begin
            m1_if.cyc = c; m1_if.stb = s; m1_if.we = w; m1_if.adr = a; m1_if.dat_w = d;
        end
    endtask

    function automatic logic stall_of(input int k);
        return (k == 0) ? m0_if.stall : m1_if.stall;
    endfunction

    // Slave model: accepts whatever the arbiter presents, acks in order the
    // cycle after acceptance unless ack_hold is set. Read data = {adr[7:0], ~adr[7:0]}.
    logic        ack_hold;
    logic        acc_seen;
    logic [15:0] acc_adr;
    logic [15:0] pend[$];
    logic [15:0] pa;

    always @(negedge clk) begin
        acc_seen = s_if.cyc & s_if.stb & ~s_if.stall;
        acc_adr  = s_if.adr;
    end

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            pend.delete();
            s_if.ack = 1'b0;
        end else begin
            if (acc_seen) pend.push_back(acc_adr);
            if (!ack_hold && pend.size() > 0) begin
                pa         = pend.pop_front();
                s_if.ack   = 1'b1;
                s_if.dat_r = {pa[7:0], ~pa[7:0]};
            end else begin
                s_if.ack = 1'b0;
            end
        end
    end

    // Monitor: every master ack must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ack_exclusive", {31'd0, m0_if.ack & m1_if.ack}, 32'd0);
            if (m0_if.ack) begin
                ack0_n++;
                chk("m0_ack_expected", {31'd0, exp0.size() != 0}, 32'd1);
                if (exp0.size() != 0) chk("m0_rdata", {16'd0, m0_if.dat_r}, {16'd0, exp0.pop_front()});
            end
            if (m1_if.ack) begin
                ack1_n++;
                chk("m1_ack_expected", {31'd0, exp1.size() != 0}, 32'd1);
                if (exp1.size() != 0) chk("m1_rdata", {16'd0, m1_if.dat_r}, {16'd0, exp1.pop_front()});
            end
        end
    end

    function automatic logic [31:0] st();
        return 32'(dut.state_q);
    endfunction

    function automatic logic [31:0] cnt();
        return 32'(dut.count_q);
    endfunction

    // Both masters raise a write in the same cycle; fw must win first.
    task automatic contention(input int fw);
        int          sw = 1 - fw;
        logic [15:0] fa = (fw == 0) ? 16'h0030 : 16'h0040;
        logic [15:0] sa = (fw == 0) ? 16'h0040 : 16'h0030;
        logic [15:0] fe = (fw == 0) ? 16'h30CF : 16'h40BF;
        logic [15:0] se = (fw == 0) ? 16'h40BF : 16'h30CF;
        tick();
        drive(0, 1, 1, 1, 16'h0030, 16'h1111);
        drive(1, 1, 1, 1, 16'h0040, 16'h2222);
        mid();
        chk("ct_idle_state", st(), 32'd0);
        chk("ct_idle_m0_stall", {31'd0, m0_if.stall}, 32'd1);
        chk("ct_idle_m1_stall", {31'd0, m1_if.stall}, 32'd1);
        tick(); mid();
        chk("ct_first_state", st(), 32'(fw + 1));
        chk("ct_first_stall", {31'd0, stall_of(fw)}, 32'd0);
        chk("ct_loser_stall", {31'd0, stall_of(sw)}, 32'd1);
        chk("ct_first_adr", {16'd0, s_if.adr}, {16'd0, fa});
        if (fw == 0) exp0.push_back(fe); else exp1.push_back(fe);
        tick();
        drive(fw, 1, 0, 1, fa, 16'h0);
        mid();
        chk("ct_loser_stall2", {31'd0, stall_of(sw)}, 32'd1);
        tick();
        drive(fw, 0, 0, 0, 16'h0, 16'h0);
        mid();
        chk("ct_release_scyc", {31'd0, s_if.cyc}, 32'd0);
        chk("ct_loser_stall3", {31'd0, stall_of(sw)}, 32'd1);
        tick(); mid();
        chk("ct_gap_state", st(), 32'd0);
        chk("ct_gap_stall", {31'd0, stall_of(sw)}, 32'd1);
        tick(); mid();
        chk("ct_second_state", st(), 32'(sw + 1));
        chk("ct_second_stall", {31'd0, stall_of(sw)}, 32'd0);
        chk("ct_second_adr", {16'd0, s_if.adr}, {16'd0, sa});
        if (sw == 0) exp0.push_back(se); else exp1.push_back(se);
        tick();
        drive(sw, 1, 0, 1, sa, 16'h0);
        tick();
        drive(sw, 0, 0, 0, 16'h0, 16'h0);
        tick(); mid();
        chk("ct_end_state", st(), 32'd0);
    endtask

    logic [15:0] rd_exp[6];
    int          issued;
    logic        saw_full;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rd_exp = '{16'h20DF, 16'h21DE, 16'h22DD, 16'h23DC, 16'h24DB, 16'h25DA};
        rst_n = 1'b0;
        ack_hold = 1'b0;
        s_if.stall = 1'b0;
        s_if.ack = 1'b0;
        s_if.dat_r = 16'h0;
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        mid();
        chk("rst_state", st(), 32'd0);
        chk("rst_count", cnt(), 32'd0);
        chk("rst_scyc", {31'd0, s_if.cyc}, 32'd0);
        chk("rst_sstb", {31'd0, s_if.stb}, 32'd0);
        chk("rst_m0_stall", {31'd0, m0_if.stall}, 32'd0);

        // First contention: m0 wins in both builds (last-grant resets to m1)
        contention(0);

        // Reset, then single zero-wait write from m0
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        tick();
        drive(0, 1, 1, 1, 16'h0010, 16'hA55A);
        mid();
        chk("wr_idle_stall", {31'd0, m0_if.stall}, 32'd1);
        chk("wr_idle_sstb", {31'd0, s_if.stb}, 32'd0);
        tick(); mid();
        chk("wr_sstb", {31'd0, s_if.stb}, 32'd1);
        chk("wr_sadr", {16'd0, s_if.adr}, 32'h0010);
        chk("wr_sdat", {16'd0, s_if.dat_w}, 32'hA55A);
        chk("wr_swe", {31'd0, s_if.we}, 32'd1);
        chk("wr_stall", {31'd0, m0_if.stall}, 32'd0);
        exp0.push_back(16'h10EF);
        tick();
        drive(0, 1, 0, 1, 16'h0010, 16'hA55A);
        mid();
        chk("wr_ack", {31'd0, m0_if.ack}, 32'd1);
        chk("wr_count1", cnt(), 32'd1);
        tick();
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        mid();
        chk("wr_count0", cnt(), 32'd0);
        tick(); mid();
        chk("wr_idle_after", st(), 32'd0);

        // Second contention: round robin now favours m1
        contention(RR);

        // Pipelined reads, slave holds acks until the counter saturates
        ack_hold = 1'b1;
        issued = 0;
        saw_full = 1'b0;
        tick();
        drive(0, 1, 1, 0, 16'h0020, 16'h0);
        for (int c = 0; c < 40 && (issued < 6 || exp0.size() > 0); c++) begin
            if (c == 6) ack_hold = 1'b0;
            mid();
            if (m0_if.stb && !m0_if.stall) begin
                exp0.push_back(rd_exp[issued]);
                issued++;
            end
            if (dut.count_q == 3'd4) begin
                saw_full = 1'b1;
                chk("pr_full_stall", {31'd0, m0_if.stall}, 32'd1);
                chk("pr_full_sstb", {31'd0, s_if.stb}, 32'd0);
            end
            tick();
            drive(0, 1, issued < 6, 0, 16'h0020 + 16'(issued), 16'h0);
        end
        chk("pr_issued", 32'(issued), 32'd6);
        chk("pr_saw_full", {31'd0, saw_full}, 32'd1);
        chk("pr_all_acked", 32'(exp0.size()), 32'd0);
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        tick(); mid();
        chk("pr_end_state", st(), 32'd0);
        chk("pr_end_count", cnt(), 32'd0);

        // Abort: m1 drops cyc with two requests outstanding
        ack_hold = 1'b1;
        tick();
        drive(1, 1, 1, 0, 16'h0050, 16'h0);
        tick(); mid();
        chk("ab_gnt_stall", {31'd0, m1_if.stall}, 32'd0);
        chk("ab_adr", {16'd0, s_if.adr}, 32'h0050);
        tick();
        drive(1, 1, 1, 0, 16'h0051, 16'h0);
        mid();
        chk("ab_count1", cnt(), 32'd1);
        tick();
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        mid();
        chk("ab_count2", cnt(), 32'd2);
        chk("ab_scyc_drop", {31'd0, s_if.cyc}, 32'd0);
        chk("ab_sstb_drop", {31'd0, s_if.stb}, 32'd0);
        tick();
        ack_hold = 1'b0;
        mid();
        chk("ab_idle_state", st(), 32'd0);
        chk("ab_idle_count", cnt(), 32'd0);
        chk("ab_late_m1_ack", {31'd0, m1_if.ack}, 32'd0);
        chk("ab_late_m0_ack", {31'd0, m0_if.ack}, 32'd0);
        tick(); mid();
        chk("ab_late_m1_ack2", {31'd0, m1_if.ack}, 32'd0);
        tick();

        // Slave stall for three cycles during an m0 write
        tick();
        drive(0, 1, 1, 1, 16'h0060, 16'h1234);
        mid();
        chk("ss_idle_stall", {31'd0, m0_if.stall}, 32'd1);
        tick();
        s_if.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("ss_stall", {31'd0, m0_if.stall}, 32'd1);
            chk("ss_sstb", {31'd0, s_if.stb}, 32'd1);
            chk("ss_count", cnt(), 32'd0);
            tick();
        end
        s_if.stall = 1'b0;
        mid();
        chk("ss_accept_stall", {31'd0, m0_if.stall}, 32'd0);
        chk("ss_sdat", {16'd0, s_if.dat_w}, 32'h1234);
        exp0.push_back(16'h609F);
        tick();
        drive(0, 1, 0, 1, 16'h0060, 16'h1234);
        mid();
        chk("ss_count1", cnt(), 32'd1);
        tick(); mid();
        chk("ss_count0", cnt(), 32'd0);
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        tick();

        // Async reset in the middle of an m0 read burst
        tick();
        drive(0, 1, 1, 0, 16'h0070, 16'h0);
        mid();
        tick(); mid();
        chk("ar_sstb", {31'd0, s_if.stb}, 32'd1);
        exp0.push_back(16'h708F);
        tick();
        drive(0, 1, 1, 0, 16'h0071, 16'h0);
        mid();
        tick();
        drive(0, 1, 1, 0, 16'h0072, 16'h0);
        #2;
        chk("ar_pre_ack", {31'd0, m0_if.ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_scyc", {31'd0, s_if.cyc}, 32'd0);
        chk("ar_sstb0", {31'd0, s_if.stb}, 32'd0);
        chk("ar_m0_ack", {31'd0, m0_if.ack}, 32'd0);
        chk("ar_m1_ack", {31'd0, m1_if.ack}, 32'd0);
        chk("ar_state", st(), 32'd0);
        chk("ar_count", cnt(), 32'd0);
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        drive(1, 1, 1, 1, 16'h0080, 16'hBEEF);
        mid();
        chk("ar_m1_idle_state", st(), 32'd0);
        chk("ar_m1_idle_stall", {31'd0, m1_if.stall}, 32'd1);
        tick(); mid();
        chk("ar_m1_gnt", st(), 32'd2);
        chk("ar_m1_stall", {31'd0, m1_if.stall}, 32'd0);
        chk("ar_m1_sdat", {16'd0, s_if.dat_w}, 32'hBEEF);
        exp1.push_back(16'h807F);
        tick();
        drive(1, 1, 0, 1, 16'h0080, 16'hBEEF);
        mid();
        chk("ar_m1_ack", {31'd0, m1_if.ack}, 32'd1);
        tick();
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        tick(); mid();
        chk("ar_end_state", st(), 32'd0);

        // Totals
        tick();
        chk("end_exp0_empty", 32'(exp0.size()), 32'd0);
        chk("end_exp1_empty", 32'(exp1.size()), 32'd0);
        chk("end_m0_acks", 32'(ack0_n), 32'd11);
        chk("end_m1_acks", 32'(ack1_n), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
